prince_sbox_d2_compress: RTL

- Downstream stage of the 3-share (d=2) PRINCE S-box monomial evaluator.
- Consumes three 14-bit monomial-share vectors in order a,b,c,d,ab,ac,ad,bc,bd,cd,abc,abd,acd,bcd.
- Per share, compresses them through the fixed linear ANF map of the PRINCE S-box into 4-bit output shares.
- Optionally refreshes the shares, then delivers them through a 2-stage valid/ready pipeline with a per-round nibble counter.

---
 rtl/prince_sbox_d2_compress_pkg.sv | 58 +++++
 rtl/prince_sbox_d2_compress_anf.sv | 25 ++
 rtl/prince_sbox_d2_compress.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/prince_sbox_d2_compress_pkg.sv
// Shared constants for the 3-share PRINCE S-box compression stage.
// Contains the S-box table, the monomial ordering, and the ANF coefficient
// matrix that is derived from the S-box at elaboration time.
package prince_d2_pkg;

  localparam int unsigned MONO_W = 14;
  localparam int unsigned SH_W   = 4;

  // PRINCE S-box, indexed by x = {d,c,b,a}
  localparam logic [SH_W-1:0] SBOX [16] = '{
    4'hB, 4'hF, 4'h3, 4'h2, 4'hA, 4'hC, 4'h9, 4'h1,
    4'h6, 4'h7, 4'h8, 4'h0, 4'hE, 4'h5, 4'hD, 4'h4
  };

  // Input-variable mask of each monomial, in the order the upstream stage
  // delivers them: a,b,c,d,ab,ac,ad,bc,bd,cd,abc,abd,acd,bcd (a = x[0])
  localparam logic [3:0] MONO_MASK [MONO_W] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'h5, 4'h9,
    4'h6, 4'hA, 4'hC, 4'h7, 4'hB, 4'hD, 4'hE
  };

  // Constant ANF term S(0), added to share 0 only
  localparam logic [SH_W-1:0] CONST0 = 4'hB;

  typedef logic [SH_W-1:0][MONO_W-1:0] anf_t;

  typedef struct packed {
    logic [SH_W-1:0] y2;
    logic [SH_W-1:0] y1;
    logic [SH_W-1:0] y0;
  } shares_t;

  // Moebius transform: coefficient of monomial m in output bit k is the XOR
  // of S(x)[k] over every x whose set bits are a subset of m.
  function automatic anf_t anf_from_sbox();
    anf_t       r;
    logic [3:0] xv;
    logic [3:0] jv;
    logic [1:0] kv;
    r = '0;
    for (int unsigned k = 0; k < SH_W; k++) begin
      kv = 2'(k);
      for (int unsigned j = 0; j < MONO_W; j++) begin
        jv = 4'(j);
        for (int unsigned x = 0; x < 16; x++) begin
          xv = 4'(x);
          if ((xv & ~MONO_MASK[jv]) == 4'h0) begin
            r[kv][jv] = r[kv][jv] ^ SBOX[xv][kv];
          end
        end
      end
    end
    return r;
  endfunction

  localparam anf_t ANF = anf_from_sbox();

endpackage

// File: rtl/prince_sbox_d2_compress_anf.sv
// Single-share linear compression of 14 monomial bits to a 4-bit S-box
// output share using the ANF coefficient matrix. Purely combinational.
module prince_anf_compress
  import prince_d2_pkg::*;
(
  input  logic [MONO_W-1:0] i_mono,
  input  logic              i_const_en,
  output logic [SH_W-1:0]   o_y
);

  logic [SH_W-1:0] w_lin;

  for (genvar k = 0; k < SH_W; k++) begin : g_bit
    assign w_lin[k] = ^(ANF[k] & i_mono);
  end

  // Add the constant term only on the share that owns it
  always_comb begin
    o_y = w_lin;
    if (i_const_en) begin
      o_y = w_lin ^ CONST0;
    end
  end

endmodule

// File: rtl/prince_sbox_d2_compress.sv
// Downstream stage of the d=2 PRINCE S-box: registers monomial shares,
// compresses each share through the ANF map, and delivers 4-bit output
// shares through a 2-stage valid/ready pipeline with a nibble counter.
// Optional zero-sum share refresh: define PRINCE_SOP_REFRESH_EN.
module prince_sbox_d2_compress
  import prince_d2_pkg::*;
#(
  parameter int unsigned NIBBLES = 16,
  parameter int unsigned CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MONO_W-1:0] mono0,
  input  logic [MONO_W-1:0] mono1,
  input  logic [MONO_W-1:0] mono2,
  input  logic [7:0]        rnd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SH_W-1:0]   y0,
  output logic [SH_W-1:0]   y1,
  output logic [SH_W-1:0]   y2,
  output logic              out_last,
  output logic [CNT_W-1:0]  nib_cnt
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  logic              r_s1_valid;
  logic [MONO_W-1:0] r_mono0;
  logic [MONO_W-1:0] r_mono1;
  logic [MONO_W-1:0] r_mono2;
  logic              r_s2_valid;
  shares_t           r_s2;
  logic [CNT_W-1:0]  r_nib_cnt;

  logic              w_s1_adv;
  logic              w_in_xfer;
  logic              w_s2_load;
  logic              w_out_xfer;
  logic [SH_W-1:0]   w_y0_c;
  logic [SH_W-1:0]   w_y1_c;
  logic [SH_W-1:0]   w_y2_c;
  shares_t           w_s2_d;

  assign w_s1_adv   = !r_s2_valid | out_ready;
  assign in_ready   = !r_s1_valid | w_s1_adv;
  assign w_in_xfer  = in_valid & in_ready;
  assign w_s2_load  = r_s1_valid & w_s1_adv;
  assign w_out_xfer = r_s2_valid & out_ready;

  prince_anf_compress u_cmp0 (
    .i_mono     (r_mono0),
    .i_const_en (1'b1),
    .o_y        (w_y0_c)
  );

  prince_anf_compress u_cmp1 (
    .i_mono     (r_mono1),
    .i_const_en (1'b0),
    .o_y        (w_y1_c)
  );

  prince_anf_compress u_cmp2 (
    .i_mono     (r_mono2),
    .i_const_en (1'b0),
    .o_y        (w_y2_c)
  );

`ifdef PRINCE_SOP_REFRESH_EN
  // Zero-sum refresh: r0 ^ r1 ^ (r0 ^ r1) cancels in the recombined value
  always_comb begin
    w_s2_d    = '0;
    w_s2_d.y0 = w_y0_c ^ rnd[3:0];
    w_s2_d.y1 = w_y1_c ^ rnd[7:4];
    w_s2_d.y2 = w_y2_c ^ rnd[3:0] ^ rnd[7:4];
  end
`else
  logic w_unused_rnd;
  assign w_unused_rnd = ^rnd;

  // Shares pass to stage 2 unrefreshed
  always_comb begin
    w_s2_d    = '0;
    w_s2_d.y0 = w_y0_c;
    w_s2_d.y1 = w_y1_c;
    w_s2_d.y2 = w_y2_c;
  end
`endif

  // Stage 1: capture monomial shares; valid follows in_valid whenever the
  // slot is free or draining this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_mono0    <= '0;
      r_mono1    <= '0;
      r_mono2    <= '0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_in_xfer) begin
        r_mono0 <= mono0;
        r_mono1 <= mono1;
        r_mono2 <= mono2;
      end
    end
  end

  // Stage 2: capture compressed shares; data holds when nothing moves in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2       <= '0;
    end else begin
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
      end
      if (w_s2_load) begin
        r_s2 <= w_s2_d;
      end
    end
  end

  // Nibble counter: advances per output transfer, wraps after NIBBLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_nib_cnt <= '0;
    end else if (w_out_xfer) begin
      if (r_nib_cnt == LAST_IDX) begin
        r_nib_cnt <= '0;
      end else begin
        r_nib_cnt <= r_nib_cnt + 1'b1;
      end
    end
  end

  assign out_valid = r_s2_valid;
  assign y0        = r_s2.y0;
  assign y1        = r_s2.y1;
  assign y2        = r_s2.y2;
  assign nib_cnt   = r_nib_cnt;
  assign out_last  = r_s2_valid & (r_nib_cnt == LAST_IDX);

endmodule
